// File: rtl/axi_ram.sv
// AXI4 slave RAM: independent write (AW/W/B) and read (AR/R) FSMs sharing one word array.
// Define AXI_RAM_BOUNDS_CHECK_EN to answer out-of-range beats with SLVERR instead of aliasing.
module axi_ram #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [1:0]          dbg_wr_state,   // 0 = W_IDLE, 1 = W_DATA, 2 = W_RESP
    output logic [1:0]          dbg_rd_state    // 0 = R_IDLE, 1 = R_WAIT, 2 = R_DATA
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a source never
    // drops valid or changes its payload until that edge, and ready never depends on valid.

    localparam int STRB_W    = DATA_W / 8;
    localparam int OFF_W     = $clog2(STRB_W);
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int OOB_SHIFT = OFF_W + IDX_W;
    localparam logic [2:0] FULL_SIZE = 3'(OFF_W);
    localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI_RAM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [1:0] burst,
                                                     input logic [7:0] len);
        logic [ADDR_W-1:0] step_addr;
        logic [ADDR_W-1:0] wrap_mask;
        step_addr = addr + ADDR_W'(STRB_W);
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << OFF_W) - ADDR_W'(1);
        case (burst)
            BURST_INCR: next_addr = step_addr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (step_addr & wrap_mask);
            default:    next_addr = addr;
        endcase
    endfunction

    function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        bad_burst = (burst == 2'b11) || (size != FULL_SIZE) ||
                    ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic              live;

    // Ready outputs stay low until the first edge after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) live <= 1'b0;
        else       live <= 1'b1;
    end

    // ---------------- write path ----------------
    w_state_t          w_state, w_state_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_bad, w_err, w_oob, w_beat, w_last_beat, w_mem_en;

    assign w_last_beat = (w_cnt == w_len);
    assign w_beat      = (w_state == W_DATA) && s_axi_wvalid;
    assign w_oob       = BOUNDS_CHECK && ((w_addr >> OOB_SHIFT) != '0);
    assign w_mem_en    = w_beat && !w_bad && !w_oob;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) w_state <= W_IDLE;
        else       w_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = live;
                if (live && s_axi_awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_last_beat) w_state_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // w_err accumulates every reason for SLVERR over the burst; bresp is read from it directly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else if (s_axi_awready && s_axi_awvalid) begin
            w_id    <= s_axi_awid;
            w_addr  <= s_axi_awaddr;
            w_len   <= s_axi_awlen;
            w_burst <= s_axi_awburst;
            w_cnt   <= '0;
            w_bad   <= bad_burst(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            w_err   <= bad_burst(s_axi_awlen, s_axi_awsize, s_axi_awburst);
        end else if (w_beat) begin
            w_addr <= next_addr(w_addr, w_burst, w_len);
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err || w_oob || (s_axi_wlast != w_last_beat);
        end
    end

    assign s_axi_bid   = w_id;
    assign s_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;

    // Memory has no reset so an aborted burst leaves earlier beats intact.
    always_ff @(posedge i_clk) begin
        if (w_mem_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[w_addr[OFF_W +: IDX_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t          r_state, r_state_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr, r_load_addr;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst, r_resp;
    logic [2:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_bad, r_last, ar_hs, ar_bad;
    logic              r_load, r_load_bad, r_load_last, r_load_oob;

    assign ar_hs      = s_axi_arready && s_axi_arvalid;
    assign ar_bad     = bad_burst(s_axi_arlen, s_axi_arsize, s_axi_arburst);
    assign r_load_oob = BOUNDS_CHECK && ((r_load_addr >> OOB_SHIFT) != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= R_IDLE;
        else       r_state <= r_state_next;
    end

    always_comb begin
        r_state_next  = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = live;
                if (live && s_axi_arvalid) r_state_next = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) r_state_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && r_last) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // A beat is fetched into the R registers when it becomes the presented beat, so the
    // payload only moves after a handshake and a same-edge write is seen as old data.
    always_comb begin
        r_load      = 1'b0;
        r_load_addr = r_addr;
        r_load_bad  = r_bad;
        r_load_last = (r_len == 8'd0);
        case (r_state)
            R_IDLE: begin
                if (ar_hs && (RD_LATENCY == 1)) begin
                    r_load      = 1'b1;
                    r_load_addr = s_axi_araddr;
                    r_load_bad  = ar_bad;
                    r_load_last = (s_axi_arlen == 8'd0);
                end
            end
            R_WAIT: r_load = (r_wait_cnt == WAIT_LAST);
            R_DATA: begin
                if (s_axi_rready && !r_last) begin
                    r_load      = 1'b1;
                    r_load_addr = next_addr(r_addr, r_burst, r_len);
                    r_load_last = ((r_cnt + 8'd1) == r_len);
                end
            end
            default: r_load = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_bad      <= 1'b0;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_resp     <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_id       <= s_axi_arid;
                r_addr     <= s_axi_araddr;
                r_len      <= s_axi_arlen;
                r_burst    <= s_axi_arburst;
                r_bad      <= ar_bad;
                r_cnt      <= '0;
                r_wait_cnt <= '0;
            end else if (r_state == R_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end
            if (r_load) begin
                r_addr <= r_load_addr;
                r_last <= r_load_last;
                if (r_state == R_DATA) r_cnt <= r_cnt + 8'd1;
                if (r_load_bad || r_load_oob) begin
                    r_data <= '0;
                    r_resp <= RESP_SLVERR;
                end else begin
                    r_data <= mem[r_load_addr[OFF_W +: IDX_W]];
                    r_resp <= RESP_OKAY;
                end
            end
        end
    end

    assign s_axi_rid    = r_id;
    assign s_axi_rdata  = r_data;
    assign s_axi_rresp  = r_resp;
    assign s_axi_rlast  = s_axi_rvalid && r_last;
    assign dbg_wr_state = w_state;
    assign dbg_rd_state = r_state;

endmodule
